// File: rtl/pattern_seq_pkg.sv
// Shared types for the programmable pattern sequencer: run modes,
// FSM states and the decoder for the raw 2-bit mode input.
package pattern_seq_pkg;

    // Sequencing mode latched at start
    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_LOOP     = 2'd1,
        MODE_PINGPONG = 2'd2
    } mode_e;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The reserved encoding 3 behaves as one-shot
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'd1:    m = MODE_LOOP;
            2'd2:    m = MODE_PINGPONG;
            default: m = MODE_ONESHOT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pattern_seq_gen_if.sv
// Control/status bundle of the pattern sequencer. The controller uses the
// master view, the sequencer itself the slave view.
interface pattern_seq_if #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [1:0]       mode;
    logic [LW-1:0]    len;
    logic             start;
    logic             stop;
    logic             step_en;

    logic [WIDTH-1:0] pat;
    logic [AW-1:0]    idx;
    logic             valid;
    logic             done;
    logic             wrap;
    logic             err;

    modport master (
        output wr_en, wr_addr, wr_data, mode, len, start, stop, step_en,
        input  pat, idx, valid, done, wrap, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, mode, len, start, stop, step_en,
        output pat, idx, valid, done, wrap, err
    );

endinterface

// File: rtl/pattern_seq_gen_table.sv
// DEPTH x WIDTH pattern register file. Every entry resets to RESET_VAL,
// one synchronous write port, combinational read port.
module pattern_table #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] w_we;

    // One-hot write enable per entry
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign w_we[gi] = i_wr_en && (i_wr_addr == AW'(gi));
        end
    endgenerate

    // Entry storage: whole table returns to RESET_VAL on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_mem[i] <= i_wr_data;
                end
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pattern_seq_gen.sv
// Programmable pattern sequencer: steps a WIDTH-bit output through the
// first len entries of a DEPTH-entry table in one-shot, loop or ping-pong
// order. All outputs are registered; pat is loaded in the same edge as idx
// so it always shows table[idx] while running.
module pattern_seq_gen
    import pattern_seq_pkg::*;
#(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(3'b101)
) (
    input  logic         clk,
    input  logic         rst_n,
    pattern_seq_if.slave bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            LW      = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    // Registered state
    state_e           r_state;
    mode_e            r_mode;
    logic             r_dir_down;
    logic [AW-1:0]    r_last;
    logic [AW-1:0]    r_idx;
    logic [WIDTH-1:0] r_pat;
    logic             r_valid;
    logic             r_done;
    logic             r_wrap;
    logic             r_err;

    // Next-state values
    state_e           w_state_next;
    mode_e            w_mode_next;
    logic             w_dir_down_next;
    logic [AW-1:0]    w_last_next;
    logic [AW-1:0]    w_idx_next;
    logic [WIDTH-1:0] w_pat_next;
    logic             w_done_next;
    logic             w_wrap_next;
    logic             w_err_next;

    // Helpers
    logic             w_pat_load;
    logic             w_pat_clear;
    logic             w_len_ok;
    logic             w_addr_bad;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_rd_data;

    // A start request is only legal for 1..DEPTH active entries
    assign w_len_ok = (bus.len != '0) && (bus.len <= DEPTH_L);

    // Out-of-range write addresses only exist when DEPTH is not a power of two
    generate
        if ((1 << AW) > DEPTH) begin : g_addr_chk
            assign w_addr_bad = ({1'b0, bus.wr_addr} >= (AW + 1)'(DEPTH));
        end else begin : g_addr_full
            assign w_addr_bad = 1'b0;
        end
    endgenerate

    // The table is frozen while a sequence runs
    assign w_wr_ok = bus.wr_en && (r_state != RUN) && !w_addr_bad;

    // Every illegal request folds into a single err pulse; a start that
    // loses to stop is not an error
    assign w_err_next = (bus.wr_en && ((r_state == RUN) || w_addr_bad))
                     || (bus.start && !bus.stop && (r_state != RUN) && !w_len_ok);

    pattern_table #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (w_idx_next),
        .o_rd_data (w_rd_data)
    );

    // Next-state, index/direction and pulse decisions
    always_comb begin
        w_state_next    = r_state;
        w_mode_next     = r_mode;
        w_dir_down_next = r_dir_down;
        w_last_next     = r_last;
        w_idx_next      = r_idx;
        w_pat_load      = 1'b0;
        w_pat_clear     = 1'b0;
        w_done_next     = 1'b0;
        w_wrap_next     = 1'b0;

        if (bus.stop) begin
            // stop overrides start and stepping in every state
            w_state_next    = IDLE;
            w_idx_next      = '0;
            w_pat_clear     = 1'b1;
            w_dir_down_next = 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start && w_len_ok) begin
                        w_state_next    = RUN;
                        w_mode_next     = decode_mode(bus.mode);
                        w_last_next     = AW'(bus.len - LW'(1));
                        w_idx_next      = '0;
                        w_dir_down_next = 1'b0;
                        w_pat_load      = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.step_en) begin
                        case (r_mode)
                            MODE_LOOP: begin
                                w_pat_load = 1'b1;
                                if (r_idx == r_last) begin
                                    w_idx_next  = '0;
                                    w_wrap_next = 1'b1;
                                end else begin
                                    w_idx_next = r_idx + AW'(1);
                                end
                            end
                            MODE_PINGPONG: begin
                                w_pat_load = 1'b1;
                                if (r_last == '0) begin
                                    // single entry: every step is a reversal
                                    w_idx_next  = '0;
                                    w_wrap_next = 1'b1;
                                end else if (!r_dir_down) begin
                                    w_idx_next = r_idx + AW'(1);
                                    if ((r_idx + AW'(1)) == r_last) begin
                                        w_wrap_next     = 1'b1;
                                        w_dir_down_next = 1'b1;
                                    end
                                end else begin
                                    w_idx_next = r_idx - AW'(1);
                                    if (r_idx == AW'(1)) begin
                                        w_wrap_next     = 1'b1;
                                        w_dir_down_next = 1'b0;
                                    end
                                end
                            end
                            default: begin
                                if (r_idx == r_last) begin
                                    // last entry stays on pat/idx through DONE
                                    w_state_next = DONE;
                                    w_done_next  = 1'b1;
                                end else begin
                                    w_idx_next = r_idx + AW'(1);
                                    w_pat_load = 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_idx_next   = '0;
                    w_pat_clear  = 1'b1;
                end
            endcase
        end
    end

    assign w_pat_next = w_pat_clear ? RESET_VAL : (w_pat_load ? w_rd_data : r_pat);

    // State, index and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mode     <= MODE_ONESHOT;
            r_dir_down <= 1'b0;
            r_last     <= '0;
            r_idx      <= '0;
            r_pat      <= RESET_VAL;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mode     <= w_mode_next;
            r_dir_down <= w_dir_down_next;
            r_last     <= w_last_next;
            r_idx      <= w_idx_next;
            r_pat      <= w_pat_next;
            r_valid    <= (w_state_next == RUN);
            r_done     <= w_done_next;
            r_wrap     <= w_wrap_next;
            r_err      <= w_err_next;
        end
    end

    assign bus.pat   = r_pat;
    assign bus.idx   = r_idx;
    assign bus.valid = r_valid;
    assign bus.done  = r_done;
    assign bus.wrap  = r_wrap;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Directed bench for pattern_seq_gen. A step-count model derives the
// expected index from closed-form sequence formulas and is compared with
// the DUT on every falling clock edge; directed steps add literal checks.
module tb_pattern_seq_gen;
    localparam int         WIDTH = 3;
    localparam int         DEPTH = 8;
    localparam logic [2:0] RST   = 3'b101;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pattern_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pattern_seq_gen #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int         m_st;      // 0 idle, 1 run, 2 done
    int         m_k;       // steps taken since start
    int         m_len;
    int         m_mode;    // 0 one-shot, 1 loop, 2 ping-pong
    logic [2:0] m_tab [DEPTH];
    logic [2:0] m_hold;
    bit         m_done, m_wrap, m_err;

    function automatic int seq_idx(input int k);
        int p, r;
        if (m_mode == 1) return k % m_len;
        if (m_mode == 2) begin
            if (m_len == 1) return 0;
            p = 2 * (m_len - 1);
            r = k % p;
            return (r < m_len) ? r : p - r;
        end
        return k;
    endfunction

    function automatic bit is_wrap(input int k);
        int i;
        if (k == 0) return 1'b0;
        if (m_mode == 1) return (k % m_len) == 0;
        if (m_mode == 2) begin
            if (m_len == 1) return 1'b1;
            i = seq_idx(k);
            return (i == 0) || (i == m_len - 1);
        end
        return 1'b0;
    endfunction

    function automatic int exp_idx();
        if (m_st == 1) return seq_idx(m_k);
        if (m_st == 2) return m_len - 1;
        return 0;
    endfunction

    function automatic int exp_pat();
        if (m_st == 1) return int'(m_tab[seq_idx(m_k)]);
        if (m_st == 2) return int'(m_hold);
        return int'(RST);
    endfunction

    task automatic model_reset();
        m_st = 0; m_k = 0; m_len = 1; m_mode = 0; m_hold = RST;
        m_done = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_tab[i] = RST;
    endtask

    task automatic model_step();
        bit wr_ok;
        m_done = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
        if (bus.wr_en && (m_st == 1 || int'(bus.wr_addr) >= DEPTH)) m_err = 1'b1;
        wr_ok = bus.wr_en && (m_st != 1) && (int'(bus.wr_addr) < DEPTH);
        if (bus.stop) begin
            m_st = 0;
        end else if (m_st != 1 && bus.start) begin
            if (int'(bus.len) >= 1 && int'(bus.len) <= DEPTH) begin
                m_st   = 1;
                m_k    = 0;
                m_len  = int'(bus.len);
                m_mode = (bus.mode == 2'd1 || bus.mode == 2'd2) ? int'(bus.mode) : 0;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_st == 1 && bus.step_en) begin
            m_k++;
            if (m_mode == 0 && m_k == m_len) begin
                m_st   = 2;
                m_done = 1'b1;
                m_hold = m_tab[m_len-1];
            end else begin
                m_wrap = is_wrap(m_k);
            end
        end
        if (wr_ok) m_tab[bus.wr_addr] = bus.wr_data;
    endtask

    // Model update on every active edge or reset assertion
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("cyc_pat",   int'(bus.pat),   exp_pat());
            check("cyc_idx",   int'(bus.idx),   exp_idx());
            check("cyc_valid", int'(bus.valid), (m_st == 1) ? 1 : 0);
            check("cyc_done",  int'(bus.done),  int'(m_done));
            check("cyc_wrap",  int'(bus.wrap),  int'(m_wrap));
            check("cyc_err",   int'(bus.err),   int'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic begin_run(input int mode, input int len, input bit step);
        bus.mode    = 2'(mode);
        bus.len     = 4'(len);
        bus.step_en = step;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    int exp_p [5] = '{'b111, 'b000, 'b011, 'b111, 'b000};
    int exp_w [6] = '{0, 0, 0, 1, 0, 0};
    int pp_i  [6] = '{0, 1, 2, 1, 0, 1};
    int pp_w  [6] = '{0, 0, 1, 0, 1, 0};

    initial begin
        model_reset();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.mode = 2'd0; bus.len = 4'd1; bus.start = 1'b0;
        bus.stop = 1'b0; bus.step_en = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset values");
        check("rst_pat", int'(bus.pat), 'b101);
        check("rst_idx", int'(bus.idx), 0);
        check("rst_valid", int'(bus.valid), 0);
        rst_n = 1'b1;

        $display("[TB] read back all entries with one-shot len 8");
        begin_run(0, 8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("rb_pat", int'(bus.pat), 'b101);
            check("rb_idx", int'(bus.idx), i);
            tick();
        end
        check("rb_done", int'(bus.done), 1);
        check("rb_valid", int'(bus.valid), 0);

        $display("[TB] write table 0:111 1:000 2:011");
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'd0; bus.wr_data = 3'b111; tick();
        check("wr_err", int'(bus.err), 0);
        bus.wr_addr = 3'd1; bus.wr_data = 3'b000; tick();
        bus.wr_addr = 3'd2; bus.wr_data = 3'b011; tick();
        bus.wr_en = 1'b0;

        $display("[TB] one-shot len 3");
        begin_run(0, 3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("os_pat", int'(bus.pat), exp_p[i]);
            tick();
        end
        check("os_done", int'(bus.done), 1);
        check("os_last_pat", int'(bus.pat), 'b011);
        check("os_valid", int'(bus.valid), 0);
        tick();
        check("os_done_clr", int'(bus.done), 0);
        check("os_hold_pat", int'(bus.pat), 'b011);

        $display("[TB] loop len 3");
        begin_run(1, 3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("lp_pat", int'(bus.pat), exp_p[i]);
            check("lp_wrap", int'(bus.wrap), exp_w[i]);
            tick();
        end
        do_stop();
        check("stop_valid", int'(bus.valid), 0);
        check("stop_pat", int'(bus.pat), 'b101);
        check("stop_idx", int'(bus.idx), 0);

        $display("[TB] ping-pong len 3, len input changed mid-run");
        begin_run(2, 3, 1'b1);
        bus.len = 4'd1;
        for (int i = 0; i < 6; i++) begin
            check("pp_idx", int'(bus.idx), pp_i[i]);
            check("pp_wrap", int'(bus.wrap), pp_w[i]);
            tick();
        end
        do_stop();

        $display("[TB] step_en toggling");
        begin_run(1, 3, 1'b0);
        check("st_idx0", int'(bus.idx), 0);
        bus.step_en = 1'b1; tick();
        check("st_idx1", int'(bus.idx), 1);
        bus.step_en = 1'b0; tick();
        check("st_hold", int'(bus.idx), 1);
        bus.step_en = 1'b1; tick();
        check("st_idx2", int'(bus.idx), 2);
        bus.step_en = 1'b0;

        $display("[TB] write during run");
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 3'b111;
        tick();
        bus.wr_en = 1'b0;
        check("rw_err", int'(bus.err), 1);
        tick();
        check("rw_err_clr", int'(bus.err), 0);
        do_stop();
        begin_run(0, 3, 1'b1);
        tick();
        check("rw_entry1", int'(bus.pat), 'b000);
        do_stop();

        $display("[TB] illegal len 0 and 9");
        begin_run(0, 0, 1'b0);
        check("len0_err", int'(bus.err), 1);
        check("len0_valid", int'(bus.valid), 0);
        tick();
        check("len0_err_clr", int'(bus.err), 0);
        begin_run(1, 9, 1'b0);
        check("len9_err", int'(bus.err), 1);
        tick();

        $display("[TB] reserved mode 3 acts as one-shot");
        begin_run(3, 2, 1'b1);
        tick();
        tick();
        check("m3_done", int'(bus.done), 1);

        $display("[TB] start and stop together in DONE");
        bus.len = 4'd2; bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check("ss_valid", int'(bus.valid), 0);
        check("ss_pat", int'(bus.pat), 'b101);
        check("ss_err", int'(bus.err), 0);

        $display("[TB] loop len 1");
        begin_run(1, 1, 1'b1);
        check("l1_wrap0", int'(bus.wrap), 0);
        tick();
        check("l1_wrap1", int'(bus.wrap), 1);
        check("l1_idx", int'(bus.idx), 0);
        tick();
        check("l1_wrap2", int'(bus.wrap), 1);
        do_stop();

        $display("[TB] ping-pong len 2");
        begin_run(2, 2, 1'b1);
        repeat (4) tick();
        do_stop();

        $display("[TB] reset during one-shot run");
        begin_run(0, 3, 1'b1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("ar_pat", int'(bus.pat), 'b101);
        check("ar_idx", int'(bus.idx), 0);
        check("ar_valid", int'(bus.valid), 0);
        check("ar_done", int'(bus.done), 0);
        tick();
        check("ar_done_hold", int'(bus.done), 0);
        rst_n = 1'b1;
        tick();
        check("ar_done_after", int'(bus.done), 0);
        check("ar_valid_after", int'(bus.valid), 0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
